// File: rtl/instr_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the instruction fetch/issue stage: instruction field
// positions, the NOP encoding, the fetch FSM state type and the source/dest
// match helper used by the interlock.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int DEST_HI = 25;
  localparam int DEST_LO = 21;
  localparam int SRC1_HI = 20;
  localparam int SRC1_LO = 16;
  localparam int SRC2_HI = 15;
  localparam int SRC2_LO = 11;
  localparam int IMM_BIT = 29;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] instr);
    return instr[DEST_HI:DEST_LO];
  endfunction

  // True when instr reads register dest. A NOP reads nothing, so it can never
  // be held up; the immediate form carries a constant in the src2 field.
  function automatic logic src_hits(input logic [31:0] instr, input logic [4:0] dest);
    logic hit;
    hit = 1'b0;
    if (instr != NOP_INSTR) begin
      if (instr[SRC1_HI:SRC1_LO] == dest) hit = 1'b1;
      if (!instr[IMM_BIT] && (instr[SRC2_HI:SRC2_LO] == dest)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage_if
// Bundles the program-load/start controls and the issue/status outputs of the
// fetch stage.
//   master: drives load_en/load_addr/load_data/prog_len/start,
//           observes InstrOut/pc/busy/done/bubble_cnt
//   slave : the fetch stage itself (opposite directions)
// -----------------------------------------------------------------------------
interface instr_fetch_stage_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic [31:0]   InstrOut;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [15:0]   bubble_cnt;

  modport master (
    output load_en, load_addr, load_data, prog_len, start,
    input  InstrOut, pc, busy, done, bubble_cnt
  );

  modport slave (
    input  load_en, load_addr, load_data, prog_len, start,
    output InstrOut, pc, busy, done, bubble_cnt
  );

endinterface

// File: rtl/instr_fetch_stage_hazard.sv
// -----------------------------------------------------------------------------
// fetch_hazard_unit
// Remembers the destinations of the two most recently issued slots and flags
// a stall when the candidate instruction reads one of them.
//   clk, rst   : clock, async active-high reset
//   i_clear    : forget all history (new run starting)
//   i_advance  : an issue slot happens this cycle (instruction or bubble)
//   i_instr    : candidate instruction at the current pc
//   o_stall    : candidate must be replaced by a bubble this cycle
// -----------------------------------------------------------------------------
module fetch_hazard_unit
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_advance,
  input  logic [31:0] i_instr,
  output logic        o_stall
);

  logic       r_h1Valid;
  logic [4:0] r_h1Dest;
  logic       r_h2Valid;
  logic [4:0] r_h2Dest;
  logic       w_hit1;
  logic       w_hit2;

  // A hit on the newest slot stalls, shifts a bubble in, then the same
  // producer sits in the older slot and stalls once more: two bubbles fall
  // out naturally, and an older-slot hit gives just one.
  assign w_hit1  = r_h1Valid && src_hits(i_instr, r_h1Dest);
  assign w_hit2  = r_h2Valid && src_hits(i_instr, r_h2Dest);
  assign o_stall = w_hit1 || w_hit2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h1Valid <= 1'b0;
      r_h1Dest  <= '0;
      r_h2Valid <= 1'b0;
      r_h2Dest  <= '0;
    end else if (i_clear) begin
      r_h1Valid <= 1'b0;
      r_h1Dest  <= '0;
      r_h2Valid <= 1'b0;
      r_h2Dest  <= '0;
    end else if (i_advance) begin
      r_h2Valid <= r_h1Valid;
      r_h2Dest  <= r_h1Dest;
      if (o_stall) begin
        r_h1Valid <= 1'b0;
        r_h1Dest  <= '0;
      end else begin
        r_h1Valid <= (i_instr != NOP_INSTR);
        r_h1Dest  <= dest_of(i_instr);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
// Loadable instruction memory, program counter and run/drain FSM feeding a
// three-stage execute pipeline with no forwarding. Bubbles are inserted so no
// instruction reads a register still in flight. One registered word per cycle.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of instr_fetch_stage_if
//              load_en/load_addr/load_data - program write (IDLE/DONE only)
//              prog_len/start              - begin a run from address 0
//              InstrOut                    - registered issued word
//              pc                          - next address to issue
//              busy/done                   - RUN or DRAIN / DONE
//              bubble_cnt                  - saturating RUN bubble count
// -----------------------------------------------------------------------------
module instr_fetch_stage
  import pipe_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LenMax = (AW+1)'(DEPTH);

  fetch_state_e  r_state;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_len;
  logic [1:0]    r_drainCnt;
  logic [31:0]   r_instrOut;
  logic [15:0]   r_bubbleCnt;
  logic [31:0]   r_mem [DEPTH];

  logic          w_idleLike;
  logic          w_startOk;
  logic          w_loadOk;
  logic          w_run;
  logic          w_stall;
  logic [31:0]   w_cand;
  logic [AW:0]   w_pcInc;
  logic [AW:0]   w_lenClamped;

  assign w_idleLike   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_startOk    = w_idleLike && bus.start;
  assign w_loadOk     = w_idleLike && bus.load_en;
  assign w_run        = (r_state == ST_RUN);
  assign w_cand       = r_mem[r_pc];
  assign w_pcInc      = {1'b0, r_pc} + (AW+1)'(1);
  assign w_lenClamped = (bus.prog_len > LenMax) ? LenMax : bus.prog_len;

  fetch_hazard_unit u_hazard (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_startOk),
    .i_advance (w_run),
    .i_instr   (w_cand),
    .o_stall   (w_stall)
  );

  // Program memory is deliberately not reset so a run can be repeated after
  // a reset without reloading.
  always_ff @(posedge clk) begin
    if (w_loadOk) begin
      r_mem[bus.load_addr] <= bus.load_data;
    end
  end

  // Fetch FSM. DRAIN lasts four edges: three NOPs flush the pipeline and the
  // fourth edge lands in DONE, so an N-instruction hazard-free program shows
  // done N+4 edges after start was sampled.
  // pc holds at DEPTH-1 after the last word of a full-memory program instead
  // of wrapping to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_len       <= '0;
      r_drainCnt  <= '0;
      r_instrOut  <= NOP_INSTR;
      r_bubbleCnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_instrOut <= NOP_INSTR;
          if (bus.start) begin
            r_pc        <= '0;
            r_len       <= w_lenClamped;
            r_bubbleCnt <= '0;
            r_drainCnt  <= '0;
            r_state     <= (w_lenClamped == '0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_stall) begin
            r_instrOut <= NOP_INSTR;
            if (r_bubbleCnt != 16'hFFFF) r_bubbleCnt <= r_bubbleCnt + 16'd1;
          end else begin
            r_instrOut <= w_cand;
            if (!w_pcInc[AW]) r_pc <= w_pcInc[AW-1:0];
            if (w_pcInc == r_len) begin
              r_drainCnt <= '0;
              r_state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_instrOut <= NOP_INSTR;
          if (r_drainCnt == 2'd3) r_state <= ST_DONE;
          else r_drainCnt <= r_drainCnt + 2'd1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_instrOut <= NOP_INSTR;
        end
      endcase
    end
  end

  assign bus.InstrOut   = r_instrOut;
  assign bus.pc         = r_pc;
  assign bus.busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.bubble_cnt = r_bubbleCnt;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
// Directed table of small programs with hand-written expected issue streams,
// hand-written reset and load/start gating sequences, and random programs
// checked against a register-scoreboard model of the no-forwarding rule.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef struct {
    string       name;
    logic [31:0] prog[4];
    int          len;
    int          nSlots;
    logic [31:0] stream[4];
    logic [3:0]  bubMask;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [31:0] tbMem [DEPTH];
  logic [31:0] expStream[$];
  bit          expBubble[$];
  vec_t        vecs[8];

  instr_fetch_stage_if #(.DEPTH(DEPTH)) bus ();

  instr_fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2);
    return {opc, d, s1, s2, 11'h000};
  endfunction

  // One comparison; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample point is 1 time unit after the edge
  task automatic applyStimulus(input logic le, input logic [AW-1:0] la, input logic [31:0] ld,
                               input logic [AW:0] pl, input logic st);
    bus.load_en   = le;
    bus.load_addr = la;
    bus.load_data = ld;
    bus.prog_len  = pl;
    bus.start     = st;
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input int addr, input logic [31:0] data);
    tbMem[addr] = data;
    applyStimulus(1'b1, AW'(addr), data, '0, 1'b0);
  endtask

  // Scoreboard model: a register written in slot p may be read no earlier
  // than slot p+3; bubbles are simply the slots spent waiting.
  task automatic buildModel(input int len);
    int lastWrite[32];
    int t;
    int earliest;
    int lim;
    logic [31:0] w;
    lim = (len > DEPTH) ? DEPTH : len;
    for (int r = 0; r < 32; r++) lastWrite[r] = -1000;
    expStream.delete();
    expBubble.delete();
    t = 0;
    for (int i = 0; i < lim; i++) begin
      w = tbMem[i];
      earliest = t;
      if (w != 32'h0) begin
        if (lastWrite[w[20:16]] + 3 > earliest) earliest = lastWrite[w[20:16]] + 3;
        if (!w[29] && (lastWrite[w[15:11]] + 3 > earliest)) earliest = lastWrite[w[15:11]] + 3;
      end
      while (t < earliest) begin
        expStream.push_back(32'h0);
        expBubble.push_back(1'b1);
        t++;
      end
      expStream.push_back(w);
      expBubble.push_back(1'b0);
      if (w != 32'h0) lastWrite[w[25:21]] = t;
      t++;
    end
  endtask

  task automatic setFromTable(input int idx);
    for (int a = 0; a < 4; a++) loadWord(a, vecs[idx].prog[a]);
    expStream.delete();
    expBubble.delete();
    for (int j = 0; j < vecs[idx].nSlots; j++) begin
      expStream.push_back(vecs[idx].stream[j]);
      expBubble.push_back(vecs[idx].bubMask[j]);
    end
  endtask

  // Start a run and follow it cycle by cycle to DONE against expStream.
  // With disturb set, a load to address 0 and a second start are attempted
  // during the first RUN cycle; both must be ignored.
  task automatic runProgram(input string tag, input int progLen, input bit disturb);
    int slots;
    int bubbles;
    int issued;
    int expPc;
    logic [31:0] exp;
    slots   = expStream.size();
    bubbles = 0;
    foreach (expBubble[b]) if (expBubble[b]) bubbles++;
    applyStimulus(1'b0, '0, 32'h0, (AW+1)'(progLen), 1'b1);
    checkOutput({tag, " start InstrOut"}, bus.InstrOut, 32'h0);
    checkOutput({tag, " start pc"}, 32'(bus.pc), 32'd0);
    checkOutput({tag, " start busy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " start done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, " start bubble_cnt"}, 32'(bus.bubble_cnt), 32'd0);
    issued = 0;
    for (int j = 0; j < slots + 4; j++) begin
      if (disturb && j == 0) applyStimulus(1'b1, '0, 32'hFFFF_FFFF, (AW+1)'(1), 1'b1);
      else applyStimulus(1'b0, '0, 32'h0, '0, 1'b0);
      exp = (j < slots) ? expStream[j] : 32'h0;
      if (j < slots && !expBubble[j]) issued++;
      expPc = (issued >= DEPTH) ? DEPTH - 1 : issued;
      checkOutput($sformatf("%s InstrOut[%0d]", tag, j), bus.InstrOut, exp);
      checkOutput($sformatf("%s pc[%0d]", tag, j), 32'(bus.pc), 32'(expPc));
      checkOutput($sformatf("%s busy[%0d]", tag, j), 32'(bus.busy), (j < slots + 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s done[%0d]", tag, j), 32'(bus.done), (j == slots + 3) ? 32'd1 : 32'd0);
    end
    checkOutput({tag, " bubble_cnt"}, 32'(bus.bubble_cnt), 32'(bubbles));
  endtask

  function automatic logic [31:0] randWord();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'h0;
    return mk((r < 3) ? 6'h08 : 6'h01, 5'($urandom_range(0, 5)),
              5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)));
  endfunction

  task automatic setVec(input int i, input string nm, input int len, input int n,
                        input logic [3:0] mask,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2, input logic [31:0] p3,
                        input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] s3);
    vecs[i].name    = nm;
    vecs[i].len     = len;
    vecs[i].nSlots  = n;
    vecs[i].bubMask = mask;
    vecs[i].prog[0] = p0;
    vecs[i].prog[1] = p1;
    vecs[i].prog[2] = p2;
    vecs[i].prog[3] = p3;
    vecs[i].stream[0] = s0;
    vecs[i].stream[1] = s1;
    vecs[i].stream[2] = s2;
    vecs[i].stream[3] = s3;
  endtask

  initial begin
    logic [31:0] a0, a1, a2, b1, c1, c2, d1, e0, e1, f1;
    int rlen;

    a0 = mk(6'h01, 5'd1, 5'd4, 5'd5);
    a1 = mk(6'h01, 5'd2, 5'd6, 5'd7);
    a2 = mk(6'h01, 5'd3, 5'd8, 5'd9);
    b1 = mk(6'h01, 5'd6, 5'd5, 5'd3);
    c1 = mk(6'h01, 5'd6, 5'd7, 5'd8);
    c2 = mk(6'h01, 5'd9, 5'd10, 5'd5);
    d1 = mk(6'h08, 5'd6, 5'd7, 5'd5);
    e0 = mk(6'h01, 5'd0, 5'd1, 5'd2);
    e1 = mk(6'h01, 5'd3, 5'd0, 5'd4);
    f1 = mk(6'h01, 5'd8, 5'd3, 5'd7);

    setVec(0, "indep", 3, 3, 4'b0000, a0, a1, a2, 32'h0, a0, a1, a2, 32'h0);
    setVec(1, "raw1", 2, 4, 4'b0110, mk(6'h01, 5'd5, 5'd1, 5'd2), b1, 32'h0, 32'h0,
           mk(6'h01, 5'd5, 5'd1, 5'd2), 32'h0, 32'h0, b1);
    setVec(2, "raw2", 3, 4, 4'b0100, mk(6'h01, 5'd5, 5'd1, 5'd2), c1, c2, 32'h0,
           mk(6'h01, 5'd5, 5'd1, 5'd2), c1, 32'h0, c2);
    setVec(3, "imm", 2, 2, 4'b0000, mk(6'h01, 5'd5, 5'd1, 5'd2), d1, 32'h0, 32'h0,
           mk(6'h01, 5'd5, 5'd1, 5'd2), d1, 32'h0, 32'h0);
    setVec(4, "nopprod", 2, 2, 4'b0000, 32'h0, mk(6'h01, 5'd6, 5'd0, 5'd0), 32'h0, 32'h0,
           32'h0, mk(6'h01, 5'd6, 5'd0, 5'd0), 32'h0, 32'h0);
    setVec(5, "dest0", 2, 4, 4'b0110, e0, e1, 32'h0, 32'h0, e0, 32'h0, 32'h0, e1);
    setVec(6, "len0", 0, 0, 4'b0000, a0, a1, a2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    setVec(7, "src2raw1", 2, 4, 4'b0110, mk(6'h01, 5'd7, 5'd1, 5'd2), f1, 32'h0, 32'h0,
           mk(6'h01, 5'd7, 5'd1, 5'd2), 32'h0, 32'h0, f1);

    // Power-on reset
    rst = 1'b1;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.prog_len = '0; bus.start = 1'b0;
    #12;
    checkOutput("reset InstrOut", bus.InstrOut, 32'h0);
    checkOutput("reset pc", 32'(bus.pc), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
    rst = 1'b0;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      setFromTable(v);
      runProgram(vecs[v].name, vecs[v].len, 1'b0);
    end

    // Load and start during RUN are ignored; the rerun issues the original I0
    setFromTable(0);
    runProgram("gate", 3, 1'b1);
    runProgram("gate rerun", 3, 1'b0);

    // Asynchronous reset in the middle of a run, then a full rerun
    setFromTable(1);
    applyStimulus(1'b0, '0, 32'h0, (AW+1)'(2), 1'b1);
    applyStimulus(1'b0, '0, 32'h0, '0, 1'b0);
    applyStimulus(1'b0, '0, 32'h0, '0, 1'b0);
    checkOutput("midrun bubble_cnt", 32'(bus.bubble_cnt), 32'd1);
    checkOutput("midrun busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async InstrOut", bus.InstrOut, 32'h0);
    checkOutput("async pc", 32'(bus.pc), 32'd0);
    checkOutput("async busy", 32'(bus.busy), 32'd0);
    checkOutput("async done", 32'(bus.done), 32'd0);
    checkOutput("async bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runProgram("after reset", 2, 1'b0);

    // Random programs against the scoreboard model
    for (int n = 0; n < 6; n++) begin
      rlen = $urandom_range(1, 20);
      for (int a = 0; a < rlen; a++) loadWord(a, randWord());
      buildModel(rlen);
      runProgram($sformatf("rand%0d", n), rlen, 1'b0);
    end

    // Full memory with an oversized length, which must clamp to DEPTH
    for (int a = 0; a < DEPTH; a++) loadWord(a, randWord());
    buildModel(100);
    runProgram("clamp", 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
